uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 Parameter PARITY_EN, default 0; 1 = one parity bit follows the data bits.
REQ-003 Parameter PARITY_ODD, default 0; 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 rx_tick  input  1  one-clk strobe at 16x baud, from the baud generator.
REQ-007 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-008 rx_ready  input  1  consumer accepts the held byte when high with rx_valid.
REQ-009 rx_data  output  DATA_BITS  received byte, LSB first on line.
REQ-010 rx_valid  output  1  rx_data holds an unread byte.
REQ-011 parity_err  output  1  parity mismatch on the byte in rx_data.
REQ-012 frame_err  output  1  stop bit sampled low on the byte in rx_data.
REQ-013 overrun_err  output  1  sticky; a frame completed while rx_valid was high.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer, reset value 1; all decisions use the synchronized value.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; the 4-bit tick counter and bit counter advance only on cycles with rx_tick=1.
REQ-016 IDLE: synchronized rx=0 on a tick -> START, tick counter cleared.
REQ-017 START: at tick count 7 (mid start bit) rx=0 -> DATA with counters cleared; rx=1 -> IDLE (glitch rejected, no output change).
REQ-018 DATA: every 16 ticks sample rx into the shift register LSB first; after DATA_BITS samples -> PARITY if PARITY_EN else STOP.
REQ-019 PARITY: after 16 ticks sample rx; parity error = (XOR of data bits XOR sampled bit) != PARITY_ODD; -> STOP.
REQ-020 STOP: after 16 ticks sample rx; frame_err = (sample==0); -> IDLE in the same clk regardless of sample value.
REQ-021 On STOP completion rx_data, parity_err, frame_err SHALL load on the next clk edge and rx_valid SHALL rise the same edge (latency: 1 clk after mid-stop tick).
REQ-022 rx_valid SHALL clear on the clk edge where rx_valid and rx_ready are both 1; rx_data and error flags hold until the next load.
REQ-023 If a frame completes while rx_valid=1 and rx_ready=0, rx_data SHALL be overwritten with the new byte, rx_valid stays 1, overrun_err sets.
REQ-024 Completion and handshake on the same edge: new byte loads, rx_valid stays 1, overrun_err unchanged.
REQ-025 overrun_err SHALL clear only on reset.
REQ-026 A frame with frame_err=1 SHALL still be delivered; the receiver SHALL not re-arm until rx is sampled high in IDLE (break holds FSM in IDLE/START loop without further output).

Reset
REQ-027 reset_n=0 SHALL immediately force FSM IDLE, counters 0, rx_data 0, rx_valid 0, all error flags 0, synchronizer flops 1.
REQ-028 Reset mid-frame SHALL discard the partial frame; no rx_valid on deassertion.

Structure
REQ-029 Shared package uart_pkg SHALL hold the rx state enum typedef and OVERSAMPLE=16, MID_SAMPLE=7 constants.
REQ-030 One sub-module uart_sync_2ff SHALL implement the synchronizer with a reset-value parameter.

Verification
REQ-031 8N1 frame 0xA5, rx_ready=0 -> rx_valid=1, rx_data=0xA5, all errors 0.
REQ-032 PARITY_EN=1 even, byte 0x03 sent with parity bit 1 -> rx_data=0x03, parity_err=1.
REQ-033 Stop bit driven 0 for byte 0x5A -> rx_data=0x5A, frame_err=1, next frame 0x11 decoded cleanly.
REQ-034 Low pulse of 4 ticks on idle line -> FSM returns to IDLE, rx_valid stays 0.
REQ-035 Two frames 0x12, 0x34 with rx_ready=0 -> rx_data=0x34, overrun_err=1; then rx_ready=1 -> rx_valid=0 after one clk.
REQ-036 reset_n pulsed low during DATA bit 4 -> all outputs 0; subsequent frame 0xC3 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive state encoding and oversampling constants
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE);

endpackage

// File: rtl/uart_sync_2ff.sv
// rtl/uart_sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit input
module uart_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver with single-byte holding register
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_tick,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
    localparam logic       ODD      = (PARITY_ODD != 0);

    logic rx_s;

    uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (rx),
        .q     (rx_s)
    );

    rx_state_e            state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 armed_q, armed_d;
    logic                 done;
    logic                 ferr_now;

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        perr_d   = perr_q;
        armed_d  = armed_q;
        done     = 1'b0;
        ferr_now = 1'b0;
        // A break (stop bit low) must see the line return high before re-arming.
        if (state_q == RX_IDLE && rx_s) armed_d = 1'b1;
        if (rx_tick) begin
            case (state_q)
                RX_IDLE: begin
                    if (!rx_s && armed_q) begin
                        state_d = RX_START;
                        tick_d  = 4'd0;
                    end
                end
                RX_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = 4'd0;
                        bit_d   = 3'd0;
                        state_d = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = 4'd0;
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == BIT_LAST) begin
                            perr_d  = 1'b0;
                            state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                RX_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = 4'd0;
                        perr_d  = ((^shreg_q) ^ rx_s) != ODD;
                        state_d = RX_STOP;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                RX_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d   = 4'd0;
                        done     = 1'b1;
                        ferr_now = !rx_s;
                        state_d  = RX_IDLE;
                        if (!rx_s) armed_d = 1'b0;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        if (done) begin
            data_d     = shreg_q;
            perr_out_d = perr_q;
            ferr_d     = ferr_now;
            valid_d    = 1'b1;
            if (valid_q && !rx_ready) ovr_d = 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RX_IDLE;
            tick_q     <= 4'd0;
            bit_q      <= 3'd0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            armed_q    <= 1'b1;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            armed_q    <= armed_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = perr_out_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed vector bench for uart_rx in 8N1 and 8E1 configurations
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_tick = 1'b0;
    logic [1:0] tick_cnt = 2'd0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       ready_a = 1'b0, ready_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_cnt <= tick_cnt + 2'd1;
        rx_tick  <= (tick_cnt == 2'd3);
    end

    uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .rx_tick(rx_tick), .rx(rx_a), .rx_ready(ready_a),
        .rx_data(data_a), .rx_valid(valid_a), .parity_err(perr_a), .frame_err(ferr_a),
        .overrun_err(ovr_a)
    );

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .rx_tick(rx_tick), .rx(rx_b), .rx_ready(ready_b),
        .rx_data(data_b), .rx_valid(valid_b), .parity_err(perr_b), .frame_err(ferr_b),
        .overrun_err(ovr_b)
    );

    typedef struct {
        logic       sel;
        logic [7:0] data;
        logic       par_en;
        logic       par_bit;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (!rx_tick) @(negedge clk);
        end
    endtask

    task automatic drive(input logic sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic send_frame(input logic sel, input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        drive(sel, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            wait_ticks(16);
        end
        if (par_en) begin
            drive(sel, par_bit);
            wait_ticks(16);
        end
        drive(sel, stop_bit);
        wait_ticks(16);
        drive(sel, 1'b1);
        wait_ticks(16);
    endtask

    task automatic wait_valid(input logic sel, input string name);
        int n = 0;
        while (((sel ? valid_b : valid_a) !== 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sel ? valid_b : valid_a), 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check("reset data_a", 32'(data_a), 32'h0);
        check("reset valid_a", 32'(valid_a), 32'h0);
        check("reset errs_a", 32'({perr_a, ferr_a, ovr_a}), 32'h0);
        check("reset valid_b", 32'(valid_b), 32'h0);
        reset_n = 1'b1;
        wait_ticks(20);

        for (int v = 0; v < 9; v++) begin
            send_frame(vecs[v].sel, vecs[v].data, vecs[v].par_en, vecs[v].par_bit, vecs[v].stop_bit);
            wait_valid(vecs[v].sel, $sformatf("vec%0d valid", v));
            check($sformatf("vec%0d data", v), 32'(vecs[v].sel ? data_b : data_a), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d perr", v), 32'(vecs[v].sel ? perr_b : perr_a), 32'(vecs[v].exp_perr));
            check($sformatf("vec%0d ferr", v), 32'(vecs[v].sel ? ferr_b : ferr_a), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d ovr", v), 32'(vecs[v].sel ? ovr_b : ovr_a), 32'h0);
            if (vecs[v].sel) ready_b = 1'b1;
            else             ready_a = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d valid clr", v), 32'(vecs[v].sel ? valid_b : valid_a), 32'h0);
            ready_a = 1'b0;
            ready_b = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d data hold", v), 32'(vecs[v].sel ? data_b : data_a), 32'(vecs[v].exp_data));
        end

        // Short low glitch on an idle line is rejected at mid start bit.
        rx_a = 1'b0;
        wait_ticks(4);
        rx_a = 1'b1;
        wait_ticks(60);
        check("glitch valid", 32'(valid_a), 32'h0);
        check("glitch state", 32'(dut_a.state_q), 32'h0);

        // Two frames with no consumer: second overwrites first and flags overrun.
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        wait_valid(1'b0, "ovr first valid");
        check("ovr first flag", 32'(ovr_a), 32'h0);
        send_frame(1'b0, 8'h34, 1'b0, 1'b0, 1'b1);
        check("ovr data", 32'(data_a), 32'h34);
        check("ovr valid", 32'(valid_a), 32'h1);
        check("ovr flag", 32'(ovr_a), 32'h1);
        ready_a = 1'b1;
        @(negedge clk);
        check("ovr valid clr", 32'(valid_a), 32'h0);
        check("ovr sticky", 32'(ovr_a), 32'h1);
        ready_a = 1'b0;
        wait_ticks(16);

        // Reset pulsed in the middle of data bit 4 discards the partial frame.
        rx_a = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx_a = 1'b1;
            wait_ticks(16);
        end
        rx_a = 1'b0;
        wait_ticks(8);
        reset_n = 1'b0;
        #1;
        check("rst data", 32'(data_a), 32'h0);
        check("rst valid", 32'(valid_a), 32'h0);
        check("rst errs", 32'({perr_a, ferr_a, ovr_a}), 32'h0);
        check("rst state", 32'(dut_a.state_q), 32'h0);
        rx_a = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        wait_ticks(60);
        check("post rst valid", 32'(valid_a), 32'h0);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        wait_valid(1'b0, "c3 valid");
        check("c3 data", 32'(data_a), 32'hC3);
        check("c3 errs", 32'({perr_a, ferr_a, ovr_a}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
